// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: bundles the game-flow controller's control and status signals.
//   master modport : drives start, N, flip_req, go and W (board / data path side);
//                    observes the strobes and status outputs.
//   slave modport  : the turn_sequencer itself.
interface turn_sequencer_if #(
  parameter int unsigned STREAK_W = 4
);
  logic                start;
  logic [1:0]          N;
  logic                flip_req;
  logic                go;
  logic                W;
  logic                A;
  logic                B;
  logic                statecombo_next_turn;
  logic [1:0]          cur_player;
  logic [1:0]          N_lat;
  logic [STREAK_W-1:0] streak;
  logic                timeout_pulse;
  logic                game_over;
  logic [1:0]          winner;
  logic [2:0]          state_dbg;

  modport master (
    output start, N, flip_req, go, W,
    input  A, B, statecombo_next_turn, cur_player, N_lat, streak,
           timeout_pulse, game_over, winner, state_dbg
  );

  modport slave (
    input  start, N, flip_req, go, W,
    output A, B, statecombo_next_turn, cur_player, N_lat, streak,
           timeout_pulse, game_over, winner, state_dbg
  );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: game-flow controller for the chicken-tile data path.
// Turns flip presses into compare (A) / move (B) strobes and turn-advance pulses,
// tracks the current player, forfeits idle turns after TIMEOUT_CYCLES and reports
// game-over and the winner.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   sif  : turn_sequencer_if.slave (start, N, flip_req, go, W in;
//          A, B, statecombo_next_turn, cur_player, N_lat, streak, timeout_pulse,
//          game_over, winner, state_dbg out)
//
// state      | meaning
// IDLE  (0)  | waiting for start, N captured on start
// WAIT  (1)  | waiting for a flip, turn timer running
// CMP   (2)  | A strobe high
// CMP_W (3)  | sample go from the data path
// MOVE  (4)  | B strobe high
// CHK   (5)  | sample W from the data path
// NXT   (6)  | turn-advance pulse, next player selected
// WIN   (7)  | game over, waiting for start to acknowledge
module turn_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 300_000_000,
  parameter int unsigned TMR_W          = 29,
  parameter int unsigned STREAK_W       = 4
) (
  input logic              clk,
  input logic              rst,
  turn_sequencer_if.slave  sif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CMP   = 3'd2,
    S_CMP_W = 3'd3,
    S_MOVE  = 3'd4,
    S_CHK   = 3'd5,
    S_NXT   = 3'd6,
    S_WIN   = 3'd7
  } state_t;

  localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = {STREAK_W{1'b1}};

  state_t              state_q, state_d;
  logic                flip_q;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          cur_player_q, cur_player_d;
  logic [1:0]          n_lat_q, n_lat_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [1:0]          winner_q, winner_d;
  logic                a_q, a_d;
  logic                b_q, b_d;
  logic                nxt_q, nxt_d;
  logic                timeout_q, timeout_d;
  logic                game_over_q, game_over_d;
  logic                flip_edge;

  // flip_q follows the button every cycle, so a held button never re-triggers
  // even if its edge was discarded outside WAIT.
  assign flip_edge = sif.flip_req & ~flip_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      flip_q       <= 1'b0;
      timer_q      <= '0;
      cur_player_q <= '0;
      n_lat_q      <= '0;
      streak_q     <= '0;
      winner_q     <= '0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      nxt_q        <= 1'b0;
      timeout_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      flip_q       <= sif.flip_req;
      timer_q      <= timer_d;
      cur_player_q <= cur_player_d;
      n_lat_q      <= n_lat_d;
      streak_q     <= streak_d;
      winner_q     <= winner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      nxt_q        <= nxt_d;
      timeout_q    <= timeout_d;
      game_over_q  <= game_over_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cur_player_d = cur_player_q;
    n_lat_d      = n_lat_q;
    streak_d     = streak_q;
    winner_d     = winner_q;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sif.start) begin
          n_lat_d      = sif.N;
          cur_player_d = '0;
          streak_d     = '0;
          timer_d      = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A flip in the final timer cycle still counts as a flip.
        if (flip_edge) begin
          timer_d = '0;
          state_d = S_CMP;
        end else if (timer_q == TMR_LAST) begin
          timer_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_NXT;
        end
      end
      S_CMP: state_d = S_CMP_W;
      S_CMP_W: begin
        if (sif.go) begin
          if (streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
          state_d = S_MOVE;
        end else begin
          state_d = S_NXT;
        end
      end
      S_MOVE: state_d = S_CHK;
      S_CHK: begin
        if (sif.W) begin
          winner_d = cur_player_q;
          state_d  = S_WIN;
        end else begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_NXT: begin
        cur_player_d = (cur_player_q == n_lat_q) ? 2'd0 : cur_player_q + 2'd1;
        streak_d     = '0;
        timer_d      = '0;
        state_d      = S_WAIT;
      end
      S_WIN: begin
        if (sif.start) begin
          winner_d = '0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered decodes of the next state: clean single-cycle pulses
    // that are mutually exclusive because the states are.
    a_d         = (state_d == S_CMP);
    b_d         = (state_d == S_MOVE);
    nxt_d       = (state_d == S_NXT);
    game_over_d = (state_d == S_WIN);
  end

  assign sif.A                    = a_q;
  assign sif.B                    = b_q;
  assign sif.statecombo_next_turn = nxt_q;
  assign sif.cur_player           = cur_player_q;
  assign sif.N_lat                = n_lat_q;
  assign sif.streak               = streak_q;
  assign sif.timeout_pulse        = timeout_q;
  assign sif.game_over            = game_over_q;
  assign sif.winner               = winner_q;
  assign sif.state_dbg            = state_q;

endmodule
